fifo_valid_prog: RTL and testbench
==================================

// Module: fifo_valid_prog
// PURPOSE
//  Next-generation synchronous FIFO with read-data qualification, guarded pointers,
//  programmable almost-full/almost-empty flags and sticky overflow/underflow status.
//  Sits between producer/consumer stages in the datapath, replacing the fixed-flag FIFO.
//  Storage is an internal register array; no external memory instance.
// PARAMETERS
//  DATA_WIDTH  8                    data word width
//  ADDR_WIDTH  8                    pointer width; DEPTH = 1<<ADDR_WIDTH
//  AF_THRESH   (1<<ADDR_WIDTH)-2    almost_full asserts when occupants >= AF_THRESH
//  AE_THRESH   2                    almost_empty asserts when occupants <= AE_THRESH
// PORTS
//  clk           in   1             single clock, all logic on posedge
//  rst           in   1             synchronous reset, active-high
//  data_in       in   DATA_WIDTH    write data
//  we            in   1             write request
//  re            in   1             read request
//  err_clr       in   1             clears sticky overflow/underflow
//  data_out      out  DATA_WIDTH    read data
//  data_valid    out  1             data_out qualifier
//  occupants     out  ADDR_WIDTH+1  stored word count, 0..DEPTH
//  empty         out  1             occupants == 0
//  full          out  1             occupants == DEPTH
//  almost_empty  out  1             occupants <= AE_THRESH
//  almost_full   out  1             occupants >= AF_THRESH
//  overflow      out  1             sticky: write attempted while full
//  underflow     out  1             sticky: read attempted while empty
// BEHAVIOUR
//  - Reset (rst=1 at posedge): wr_ptr=rd_ptr=0, occupants=0, data_out=0, data_valid=0,
//    overflow=underflow=0; hence empty=1, full=0, almost_empty=1, almost_full=0.
//    Reset mid-operation discards all contents; array contents not cleared.
//  - wr_acc = we & ~full; rd_acc = re & ~empty (both from registered occupants).
//  - wr_acc: mem[wr_ptr[ADDR_WIDTH-1:0]] <= data_in, wr_ptr++. rd_acc: rd_ptr++.
//  - Pointers ADDR_WIDTH+1 bits; index uses low bits; wrap modulo DEPTH, no special case.
//  - occupants: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
//  - Full + we + re: read accepted, write rejected, overflow set, occupants -> DEPTH-1.
//  - Empty + we + re: write accepted, read rejected, underflow set, occupants -> 1.
//  - overflow <= 1 on we&full; underflow <= 1 on re&empty; both held until err_clr or rst.
//    err_clr and a new error in the same cycle: error wins (flag stays 1).
//  - Flags full/empty/almost_* combinational from registered occupants (no extra latency).
//  - Standard mode: data_out <= mem[rd_ptr] on rd_acc, else holds previous value;
//    data_valid <= rd_acc (1-cycle pulse, 1-cycle read latency). Rejected reads never
//    raise data_valid.
//  - Thresholds outside 0..DEPTH legal; flags then constant (e.g., AF_THRESH=0 -> always 1).
// CONFIGURATION
//  FIFO_VALID_FWFT_EN defined: first-word-fall-through. data_out = mem[rd_ptr]
//    combinationally; data_valid = ~empty; re acts as pop/acknowledge; zero read latency;
//    data_out value when empty is don't-care. Accept/flag/error rules unchanged.
//  Not defined: standard registered-read mode as above.
// TESTING
//  1 Reset: rst=1 two cycles -> occupants=0, empty=1, almost_empty=1, data_valid=0, data_out=0.
//  2 Fill/drain (ADDR_WIDTH=3): write 0x01..0x08 -> full=1 at occupants=8, almost_full at 6;
//    read 8 -> data_valid pulses 1 cycle after each re, data 0x01..0x08 in order, empty=1.
//  3 Overflow: at full, we=1 with 0xAA -> occupants stays 8, overflow=1, 0xAA never read;
//    err_clr=1 -> overflow=0.
//  4 Underflow: empty, re=1 -> underflow=1, data_valid=0, occupants=0, pointers unchanged.
//  5 Simultaneous: occupants=4, we=re=1 for 20 cycles -> occupants stays 4, pointers wrap
//    past 7, output sequence matches input order.
//  6 FWFT build: write 0x5A to empty FIFO -> next cycle data_valid=1, data_out=0x5A
//    without re; re=1 -> empty=1, data_valid=0 following cycle.

Source files
------------

// File: rtl/fifo_valid_prog_if.sv
// fifo_valid_prog_if: producer/consumer bus of the programmable-flag FIFO.
//   master : write data/request, read request, error clear; observes read data and status
//   slave  : the FIFO itself
// Signals: data_in, we, re, err_clr (to FIFO); data_out, data_valid, occupants, empty,
//          full, almost_empty, almost_full, overflow, underflow (from FIFO).
interface fifo_valid_prog_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  we;
  logic                  re;
  logic                  err_clr;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic [ADDR_WIDTH:0]   occupants;
  logic                  empty;
  logic                  full;
  logic                  almost_empty;
  logic                  almost_full;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output data_in, we, re, err_clr,
    input  data_out, data_valid, occupants, empty, full,
           almost_empty, almost_full, overflow, underflow
  );

  modport slave (
    input  data_in, we, re, err_clr,
    output data_out, data_valid, occupants, empty, full,
           almost_empty, almost_full, overflow, underflow
  );
endinterface

// File: rtl/fifo_valid_prog.sv
// fifo_valid_prog: synchronous register-array FIFO with read-data qualification,
// programmable almost-full/almost-empty thresholds and sticky overflow/underflow.
// Ports:
//   clk  - single clock, posedge
//   rst  - synchronous reset, active-high (pointers/count/status cleared, array kept)
//   bus  - fifo_valid_prog_if.slave (data_in/we/re/err_clr in; data_out/data_valid/
//          occupants/empty/full/almost_empty/almost_full/overflow/underflow out)
// Build option: define FIFO_VALID_FWFT_EN for first-word-fall-through reads
// (data_out shows the head word combinationally, data_valid = ~empty, re pops).
// Default build: registered read, data_valid pulses one cycle after an accepted read.
module fifo_valid_prog #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int AE_THRESH  = 2
) (
  input logic           clk,
  input logic           rst,
  fifo_valid_prog_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr, occ;
  logic [ADDR_WIDTH-1:0] wr_idx, rd_idx;
  logic                  is_full, is_empty, wr_acc, rd_acc;
  logic                  ov, uf;
  int                    occ_i;

  assign wr_idx   = wr_ptr[ADDR_WIDTH-1:0];
  assign rd_idx   = rd_ptr[ADDR_WIDTH-1:0];
  assign is_full  = (occ == FULL_CNT);
  assign is_empty = (occ == '0);
  // Thresholds are compared as signed ints so out-of-range values just pin the flag.
  assign occ_i    = int'(occ);
  assign wr_acc   = bus.we & ~is_full;
  assign rd_acc   = bus.re & ~is_empty;

  assign bus.occupants    = occ;
  assign bus.full         = is_full;
  assign bus.empty        = is_empty;
  assign bus.almost_full  = (occ_i >= AF_THRESH);
  assign bus.almost_empty = (occ_i <= AE_THRESH);
  assign bus.overflow     = ov;
  assign bus.underflow    = uf;

  // Storage has no reset; stale words are unreachable once pointers are cleared.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem[wr_idx] <= bus.data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      ov     <= 1'b0;
      uf     <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_acc, rd_acc})
        2'b10:   occ <= occ + PTR_ONE;
        2'b01:   occ <= occ - PTR_ONE;
        default: occ <= occ;
      endcase
      // A new error in the same cycle as err_clr keeps the flag set.
      ov <= (bus.we & is_full)  | (ov & ~bus.err_clr);
      uf <= (bus.re & is_empty) | (uf & ~bus.err_clr);
    end
  end

`ifdef FIFO_VALID_FWFT_EN
  assign bus.data_out   = mem[rd_idx];
  assign bus.data_valid = ~is_empty;
`else
  logic [DATA_WIDTH-1:0] data_q;
  logic                  vld_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= rd_acc;
      if (rd_acc) data_q <= mem[rd_idx];
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = vld_q;
`endif
endmodule

// File: tb/tb_fifo_valid_prog.sv
// tb_fifo_valid_prog: randomized + directed bench for fifo_valid_prog (ADDR_WIDTH=3).
// The reference is a plain data queue; accepted reads push the expected word into a
// scoreboard queue that an independent negedge monitor pops when data_valid is seen.
module tb_fifo_valid_prog;
  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_valid_prog_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fifo_valid_prog #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mq[$];    // reference FIFO contents, head first
  logic [DW-1:0] expq[$];  // words due on data_out at the next monitor sample
  logic [DW-1:0] last_out;
  bit            m_ov, m_uf;
  bit            mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model advances at the same edge the DUT does.
  task automatic cyc(input bit w, input bit r, input logic [DW-1:0] d,
                     input bit c, input bit rs);
    bit fl, em, wa, ra;
    rst         = rs;
    bus.we      = w;
    bus.re      = r;
    bus.data_in = d;
    bus.err_clr = c;
    fl = (mq.size() == DEPTH);
    em = (mq.size() == 0);
    wa = w && !fl;
    ra = r && !em;
    @(posedge clk);
    if (rs) begin
      mq.delete();
      m_ov     = 1'b0;
      m_uf     = 1'b0;
      last_out = '0;
    end else begin
      if (ra) begin
        last_out = mq.pop_front();
`ifndef FIFO_VALID_FWFT_EN
        expq.push_back(last_out);
`endif
      end
      if (wa) mq.push_back(d);
      m_ov = (w && fl) || (m_ov && !c);
      m_uf = (r && em) || (m_uf && !c);
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("occupants",    bus.occupants,    mq.size());
      chk("empty",        bus.empty,        mq.size() == 0);
      chk("full",         bus.full,         mq.size() == DEPTH);
      chk("almost_empty", bus.almost_empty, mq.size() <= AE);
      chk("almost_full",  bus.almost_full,  mq.size() >= AF);
      chk("overflow",     bus.overflow,     m_ov);
      chk("underflow",    bus.underflow,    m_uf);
`ifdef FIFO_VALID_FWFT_EN
      chk("data_valid", bus.data_valid, mq.size() != 0);
      if (mq.size() != 0) chk("data_out_head", bus.data_out, mq[0]);
`else
      chk("data_valid", bus.data_valid, expq.size() != 0);
      if (expq.size() != 0) chk("data_out_read", bus.data_out, expq.pop_front());
      chk("data_out_hold", bus.data_out, last_out);
`endif
    end
  end

  initial begin
    int pw, pr;
    rst = 1'b1; bus.we = 1'b0; bus.re = 1'b0; bus.data_in = '0; bus.err_clr = 1'b0;
    last_out = '0;

    // Reset held two cycles.
    cyc(0, 0, 8'h00, 0, 1);
    mon_en = 1'b1;
    cyc(0, 0, 8'h00, 0, 1);

    // Fill 0x01..0x08, then overflow attempts.
    for (int i = 1; i <= DEPTH; i++) cyc(1, 0, DW'(i), 0, 0);
    cyc(1, 0, 8'hAA, 0, 0);
    cyc(1, 0, 8'hAB, 1, 0);   // new error beats err_clr
    cyc(0, 0, 8'h00, 1, 0);   // clears
    cyc(1, 1, 8'hCC, 0, 0);   // full: read wins, write rejected
    cyc(1, 0, 8'hCD, 1, 0);   // refill to full, clear overflow
    // Drain past empty, then empty + we + re.
    for (int i = 0; i <= DEPTH; i++) cyc(0, 1, 8'h00, 0, 0);
    cyc(1, 1, 8'h77, 0, 0);
    cyc(0, 0, 8'h00, 1, 0);
    // Build to 4 and stream through with pointers wrapping.
    for (int i = 0; i < 3; i++) cyc(1, 0, DW'(8'h10 + i), 0, 0);
    for (int i = 0; i < 20; i++) cyc(1, 1, DW'(8'h40 + i), 0, 0);
    // Reset mid-operation, then resume.
    cyc(1, 1, 8'hEE, 0, 1);
    cyc(1, 0, 8'h5A, 0, 0);
    cyc(0, 0, 8'h00, 0, 0);
    cyc(0, 1, 8'h00, 0, 0);

    // Random phases with write/read bias so both full and empty are visited.
    for (int ph = 0; ph < 15; ph++) begin
      case (ph % 3)
        0:       begin pw = 80; pr = 30; end
        1:       begin pw = 50; pr = 50; end
        default: begin pw = 25; pr = 80; end
      endcase
      for (int i = 0; i < 200; i++)
        cyc($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
            DW'($urandom), $urandom_range(0, 99) < 5, $urandom_range(0, 999) < 4);
    end

    for (int i = 0; i <= DEPTH; i++) cyc(0, 1, 8'h00, 0, 0);
    cyc(0, 0, 8'h00, 1, 0);
    cyc(0, 0, 8'h00, 0, 0);
    @(posedge clk);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
